sliding_detector_pipelined: RTL and testbench

Registered, multi-slice successor to the single-slice sliding detector. Each valid cycle it evaluates `num_of_slices` independent residual-error windows against a null hypothesis plus `num_of_flip_patterns` flip patterns, picks the minimum-energy hypothesis per slice, and reports it two cycles later with a valid strobe. It sits between the FFE/residual-error path and the error-correction stage of the digital back end. Optional per-hypothesis hit counters support BER estimation.

---
 rtl/sliding_detector_pipelined.sv | 177 +++++++++++++++++
 tb/tb_sliding_detector_pipelined.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_detector_pipelined.sv
// Two-stage multi-slice sliding detector: per-slice minimum-energy flip hypothesis with valid strobe.
// Define SLIDING_DET_STATS_EN to compile in the per-hypothesis hit counters and clear_stats.
module sliding_detector_pipelined #(
  parameter int num_of_slices        = 4,
  parameter int seq_length           = 3,
  parameter int num_of_flip_patterns = 4,
  parameter int flip_pattern_depth   = 3,
  parameter bit flip_patterns [num_of_flip_patterns][flip_pattern_depth] =
    '{'{0,1,0}, '{0,1,1}, '{1,1,1}, '{1,0,1}},
  parameter int est_error_bitwidth   = 8,
  parameter int est_channel_bitwidth = 8,
  parameter int ener_bitwidth        = 18,
  parameter int count_bitwidth       = 16,
  localparam int FW = $clog2(num_of_flip_patterns + 1),
  localparam int CH = flip_pattern_depth + seq_length - 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic signed [est_error_bitwidth-1:0]   residual_error_trace [num_of_slices][seq_length],
  input  logic        [seq_length-1:0]           bits [num_of_slices],
  input  logic signed [est_channel_bitwidth-1:0] channel [CH],
  input  logic        [3:0]                      channel_shift,
  input  logic                                   clear_stats,
  output logic                                   out_valid,
  output logic        [FW-1:0]                   error_flag [num_of_slices],
  output logic        [ener_bitwidth-1:0]        mmse_val [num_of_slices],
  output logic        [num_of_flip_patterns-1:0] overflow [num_of_slices],
  output logic        [count_bitwidth-1:0]       hit_count [num_of_flip_patterns+1]
);

  localparam int W  = 2*est_error_bitwidth + $clog2(seq_length);
  localparam int SW = est_error_bitwidth + est_channel_bitwidth + $clog2(flip_pattern_depth) + 4;
  localparam int XW = W + ener_bitwidth;
  localparam int NH = num_of_flip_patterns + 1;
  localparam logic signed [SW-1:0] RES_MAX = SW'((1 << (est_error_bitwidth-1)) - 1);
  localparam logic signed [SW-1:0] RES_MIN = ~RES_MAX;

  function automatic logic [W-1:0] square(input logic signed [est_error_bitwidth-1:0] x);
    logic signed [2*est_error_bitwidth-1:0] xe;
    xe = (2*est_error_bitwidth)'(x);
    return W'($unsigned(xe * xe));
  endfunction

  logic [1:0]                      vld;
  logic [W-1:0]                    ener_d [num_of_slices][NH];
  logic [W-1:0]                    ener_q [num_of_slices][NH];
  logic [num_of_flip_patterns-1:0] ovf_d  [num_of_slices];
  logic [num_of_flip_patterns-1:0] ovf_q  [num_of_slices];
  logic [FW-1:0]                   flag_d [num_of_slices];
  logic [ener_bitwidth-1:0]        mmse_d [num_of_slices];

  // Stage 1: null energy plus, per pattern, the energy of the residual with the injected error.
  always_comb begin
    logic signed [SW-1:0]                 acc;
    logic signed [est_error_bitwidth-1:0] rs;
    logic [W-1:0]                         e_sum;
    logic [num_of_flip_patterns-1:0]      ovf;
    // NOTE: every local is given a value before it is read, so no latch is inferred.
    acc   = '0;
    rs    = '0;
    e_sum = '0;
    ovf   = '0;
    for (int s = 0; s < num_of_slices; s++) begin
      e_sum = '0;
      for (int k = 0; k < seq_length; k++)
        e_sum = e_sum + square(residual_error_trace[s][k]);
      ener_d[s][0] = e_sum;
      ovf = '0;
      for (int p = 0; p < num_of_flip_patterns; p++) begin
        e_sum = '0;
        for (int k = 0; k < seq_length; k++) begin
          acc = '0;
          for (int j = 0; j < flip_pattern_depth; j++) begin
            if (flip_patterns[p][j]) begin
              if (bits[s][j]) acc = acc + (SW'(channel[k + flip_pattern_depth - 1 - j]) <<< 1);
              else            acc = acc - (SW'(channel[k + flip_pattern_depth - 1 - j]) <<< 1);
            end
          end
          acc = (acc >>> channel_shift) + SW'(residual_error_trace[s][k]);
          if (acc > RES_MAX) begin
            rs     = RES_MAX[est_error_bitwidth-1:0];
            ovf[p] = 1'b1;
          end else if (acc < RES_MIN) begin
            rs     = RES_MIN[est_error_bitwidth-1:0];
            ovf[p] = 1'b1;
          end else begin
            rs = acc[est_error_bitwidth-1:0];
          end
          e_sum = e_sum + square(rs);
        end
        ener_d[s][p+1] = e_sum;
      end
      ovf_d[s] = ovf;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset as well, because every output must read zero after reset.
    if (rst) begin
      vld    <= '0;
      ener_q <= '{default: '0};
      ovf_q  <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments make all updates at this edge order-independent.
      vld <= {vld[0], in_valid};
      if (in_valid) begin
        ener_q <= ener_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  // Stage 2: ascending scan with strict comparison so ties keep the lower hypothesis index.
  always_comb begin
    logic [W-1:0]  best;
    logic [FW-1:0] win;
    logic [XW-1:0] half;
    best = '0;
    win  = '0;
    half = '0;
    for (int s = 0; s < num_of_slices; s++) begin
      best = ener_q[s][0];
      win  = '0;
      for (int h = 1; h < NH; h++) begin
        if (best > ener_q[s][h]) begin
          best = ener_q[s][h];
          win  = FW'(h);
        end
      end
      flag_d[s] = win;
      half      = XW'(best >> 1);
      mmse_d[s] = (|(half >> ener_bitwidth)) ? '1 : half[ener_bitwidth-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      error_flag <= '{default: '0};
      mmse_val   <= '{default: '0};
      overflow   <= '{default: '0};
    end else if (vld[0]) begin
      error_flag <= flag_d;
      mmse_val   <= mmse_d;
      overflow   <= ovf_q;
    end
  end

  assign out_valid = vld[1];

`ifdef SLIDING_DET_STATS_EN
  localparam int TW = count_bitwidth + $clog2(num_of_slices + 1);
  logic [count_bitwidth-1:0] hit_next [NH];

  always_comb begin
    logic [TW-1:0] sum;
    sum = '0;
    for (int h = 0; h < NH; h++) begin
      sum = TW'(hit_count[h]);
      for (int s = 0; s < num_of_slices; s++)
        if (error_flag[s] == FW'(h)) sum = sum + TW'(1);
      hit_next[h] = (|sum[TW-1:count_bitwidth]) ? '1 : sum[count_bitwidth-1:0];
    end
  end

  // clear_stats takes priority over counting the result presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) hit_count <= '{default: '0};
    else if (out_valid)     hit_count <= hit_next;
  end
`else
  logic unused_clear_stats;
  assign unused_clear_stats = clear_stats;
  assign hit_count          = '{default: '0};
`endif

endmodule

// File: tb/tb_sliding_detector_pipelined.sv
// Self-checking bench for sliding_detector_pipelined: directed corner cases plus randomized traffic
// compared against an arithmetic reference model with a latency/hold scoreboard.
module tb_sliding_detector_pipelined;
  localparam int NS = 4, L = 3, P = 4, D = 3, E = 8, C = 8, EW = 18, CW = 16;
  localparam int FW = 3, CH = D + L - 1;
  localparam int FLIPS [P][D] = '{'{0,1,0}, '{0,1,1}, '{1,1,1}, '{1,0,1}};

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic signed [E-1:0]   residual_error_trace [NS][L];
  logic        [L-1:0]   bits [NS];
  logic signed [C-1:0]   channel [CH];
  logic        [3:0]     channel_shift;
  logic                  clear_stats;
  logic                  out_valid;
  logic        [FW-1:0]  error_flag [NS];
  logic        [EW-1:0]  mmse_val [NS];
  logic        [P-1:0]   overflow [NS];
  logic        [CW-1:0]  hit_count [P+1];

  sliding_detector_pipelined dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .residual_error_trace (residual_error_trace),
    .bits                 (bits),
    .channel              (channel),
    .channel_shift        (channel_shift),
    .clear_stats          (clear_stats),
    .out_valid            (out_valid),
    .error_flag           (error_flag),
    .mmse_val             (mmse_val),
    .overflow             (overflow),
    .hit_count            (hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       flag;
    int       mmse;
    bit [P-1:0] ovf;
  } slice_res_t;

  int total = 0;
  int bad   = 0;

  // Scoreboard state: result sampled at the last edge, the held output, and expected counters.
  slice_res_t s1_res [NS];
  bit         s1_vld;
  slice_res_t held [NS];
  bit         exp_vld;
  int         exp_cnt [P+1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: energies from the hypothesis rules, then the lowest index holding the minimum.
  function automatic slice_res_t ref_slice(input int s);
    int m [P+1];
    int r, inj, best;
    slice_res_t res;
    res.ovf = '0;
    m[0] = 0;
    for (int k = 0; k < L; k++) begin
      r = int'(residual_error_trace[s][k]);
      m[0] += r * r;
    end
    for (int p = 0; p < P; p++) begin
      m[p+1] = 0;
      for (int k = 0; k < L; k++) begin
        inj = 0;
        for (int j = 0; j < D; j++)
          if (FLIPS[p][j] != 0) inj += (bits[s][j] ? 2 : -2) * int'(channel[k + D - 1 - j]);
        inj = inj >>> int'(channel_shift);
        r = int'(residual_error_trace[s][k]) + inj;
        if (r > 127)       begin r = 127;  res.ovf[p] = 1'b1; end
        else if (r < -128) begin r = -128; res.ovf[p] = 1'b1; end
        m[p+1] += r * r;
      end
    end
    best = m[0];
    for (int h = 1; h <= P; h++) if (m[h] < best) best = m[h];
    res.flag = 0;
    for (int h = P; h >= 0; h--) if (m[h] == best) res.flag = h;
    res.mmse = m[res.flag] / 2;
    if (res.mmse > (1 << EW) - 1) res.mmse = (1 << EW) - 1;
    return res;
  endfunction

  task automatic clear_model();
    s1_vld  = 1'b0;
    exp_vld = 1'b0;
    for (int s = 0; s < NS; s++) begin
      held[s]   = '{flag: 0, mmse: 0, ovf: '0};
      s1_res[s] = '{flag: 0, mmse: 0, ovf: '0};
    end
    for (int h = 0; h <= P; h++) exp_cnt[h] = 0;
  endtask

  // Advance one clock with the currently driven inputs, then compare every output.
  task automatic step();
    slice_res_t now_res [NS];
    for (int s = 0; s < NS; s++) now_res[s] = ref_slice(s);
    if (rst) begin
      clear_model();
    end else begin
`ifdef SLIDING_DET_STATS_EN
      if (clear_stats) begin
        for (int h = 0; h <= P; h++) exp_cnt[h] = 0;
      end else if (exp_vld) begin
        for (int s = 0; s < NS; s++)
          if (exp_cnt[held[s].flag] < (1 << CW) - 1) exp_cnt[held[s].flag]++;
      end
`endif
      exp_vld = s1_vld;
      if (s1_vld) held = s1_res;
      s1_vld = in_valid;
      if (in_valid) s1_res = now_res;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, exp_vld);
    for (int s = 0; s < NS; s++) begin
      check($sformatf("error_flag[%0d]", s), error_flag[s], held[s].flag);
      check($sformatf("mmse_val[%0d]", s), mmse_val[s], held[s].mmse);
      check($sformatf("overflow[%0d]", s), overflow[s], held[s].ovf);
    end
    for (int h = 0; h <= P; h++)
      check($sformatf("hit_count[%0d]", h), hit_count[h], exp_cnt[h]);
  endtask

  task automatic drive_zero();
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < L; k++) residual_error_trace[s][k] = '0;
      bits[s] = '0;
    end
    for (int t = 0; t < CH; t++) channel[t] = '0;
    channel_shift = '0;
  endtask

  task automatic drive_random(input bit wide);
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < L; k++)
        residual_error_trace[s][k] = wide ? E'($urandom) : E'($urandom_range(0, 32) - 16);
      bits[s] = L'($urandom);
    end
    for (int t = 0; t < CH; t++)
      channel[t] = wide ? C'($urandom) : C'($urandom_range(0, 40) - 20);
    channel_shift = 4'($urandom_range(0, 3));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; clear_stats = 1'b0;
    drive_zero();
    clear_model();
    step();
    step();
    rst = 1'b0;
    step();

    // Single zero pulse: one-cycle out_valid, all flags and energies zero.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();

    // Centre-tap pattern {0,1,0} cancels a -4 residual exactly.
    drive_zero();
    for (int s = 0; s < NS; s++) bits[s] = 3'b111;
    residual_error_trace[0][1] = -8'sd4;
    channel[2] = 8'sd8;
    channel_shift = 4'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("cancel_flag", error_flag[0], 1);
    check("cancel_mmse", mmse_val[0], 0);
    step();

    // Saturation: every pattern clips to +127, so all energies equal the null energy.
    drive_zero();
    for (int s = 0; s < NS; s++) bits[s] = 3'b111;
    for (int k = 0; k < L; k++) residual_error_trace[0][k] = 8'sd127;
    for (int t = 0; t < CH; t++) channel[t] = 8'sd100;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("sat_overflow", overflow[0], 4'hf);
    check("sat_flag", error_flag[0], 0);
    check("sat_mmse", mmse_val[0], 24193);
    step();

    // Tie: M0 == M1 == 4 keeps the null hypothesis.
    drive_zero();
    for (int s = 0; s < NS; s++) bits[s] = 3'b111;
    residual_error_trace[0][1] = -8'sd2;
    channel[2] = 8'sd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("tie_flag", error_flag[0], 0);
    check("tie_mmse", mmse_val[0], 2);
    step();

    // Ten back-to-back valids with a reset on the fifth.
    for (int i = 0; i < 10; i++) begin
      drive_random(1'b0);
      in_valid = 1'b1;
      rst = (i == 4);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();

    // Randomized traffic with gaps, mixed ranges and occasional clear_stats.
    for (int i = 0; i < 400; i++) begin
      drive_random($urandom_range(0, 3) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      clear_stats = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 1'b0;
    clear_stats = 1'b0;
    repeat (3) step();

`ifdef SLIDING_DET_STATS_EN
    // Counter saturation on hypothesis 0, then clear coinciding with out_valid.
    drive_zero();
    in_valid = 1'b1;
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    for (int i = 0; i < 16400; i++) step();
    check("hit_sat", hit_count[0], 16'hffff);
    check("clear_with_valid_pre", out_valid, 1'b1);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    for (int h = 0; h <= P; h++) check($sformatf("cleared[%0d]", h), hit_count[h], 0);
    in_valid = 1'b0;
    repeat (3) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
